// File: rtl/accum_bank.sv
// rtl/accum_bank.sv - bank of accumulators with single-cycle ALU ops and a bit-serial shift-add multiply
module accum_bank #(
  parameter int WIDTH   = 32,
  parameter int NUM_ACC = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 opcode,
  input  logic [$clog2(NUM_ACC)-1:0] acc_sel,
  input  logic [WIDTH-1:0]           operand,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic                       carry,
  output logic                       zero
);

  localparam int SEL_W = $clog2(NUM_ACC);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_LOAD = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_CLR  = 4'h9;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] acc [NUM_ACC];

  logic             accept;
  logic             mul_start;
  logic             mul_done;

  logic [WIDTH-1:0] sel_acc;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             shift_big;
  logic [SH_W-1:0]  sh_amt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_wr;
  logic             alu_carry_wr;
  logic             alu_carry;

  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0] mul_prod_next;
  logic [CNT_W-1:0] mul_cnt;
  logic [SEL_W-1:0] mul_sel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = (state == S_IDLE);
    accept     = in_valid && in_ready;
    mul_start  = 1'b0;
    mul_done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept && opcode == OP_MUL) begin
          state_next = S_MUL;
          mul_start  = 1'b1;
        end
      end
      S_MUL: begin
        if (mul_cnt == LAST_CNT) begin
          state_next = S_IDLE;
          mul_done   = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shift counts are judged on the whole operand so that any count >= WIDTH clears the result.
  always_comb begin
    sel_acc      = acc[acc_sel];
    sum          = {1'b0, sel_acc} + {1'b0, operand};
    diff         = sel_acc - operand;
    shift_big    = (operand >= WIDTH_VAL);
    sh_amt       = operand[SH_W-1:0];
    alu_res      = sel_acc;
    alu_wr       = 1'b0;
    alu_carry_wr = 1'b0;
    alu_carry    = carry;
    unique case (opcode)
      OP_ADD: begin
        alu_res      = sum[WIDTH-1:0];
        alu_wr       = 1'b1;
        alu_carry_wr = 1'b1;
        alu_carry    = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res      = diff;
        alu_wr       = 1'b1;
        alu_carry_wr = 1'b1;
        alu_carry    = (sel_acc < operand);
      end
      OP_LOAD: begin
        alu_res = operand;
        alu_wr  = 1'b1;
      end
      OP_AND: begin
        alu_res = sel_acc & operand;
        alu_wr  = 1'b1;
      end
      OP_OR: begin
        alu_res = sel_acc | operand;
        alu_wr  = 1'b1;
      end
      OP_XOR: begin
        alu_res = sel_acc ^ operand;
        alu_wr  = 1'b1;
      end
      OP_SHL: begin
        alu_res = shift_big ? '0 : (sel_acc << sh_amt);
        alu_wr  = 1'b1;
      end
      OP_SHR: begin
        alu_res = shift_big ? '0 : (sel_acc >> sh_amt);
        alu_wr  = 1'b1;
      end
      OP_CLR: begin
        alu_res = '0;
        alu_wr  = 1'b1;
      end
      default: begin
        alu_res = sel_acc;
        alu_wr  = 1'b0;
      end
    endcase
  end

  // One multiplier bit per cycle; the final step is folded into the write-back edge.
  always_comb begin
    mul_prod_next = mul_prod + (mul_b[0] ? mul_a : '0);
  end

  always_ff @(posedge clk) begin
    out_valid <= 1'b0;
    if (!reset) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        acc[i] <= '0;
      end
      out      <= '0;
      carry    <= 1'b0;
      zero     <= 1'b1;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_prod <= '0;
      mul_cnt  <= '0;
      mul_sel  <= '0;
    end else if (mul_start) begin
      mul_a    <= sel_acc;
      mul_b    <= operand;
      mul_prod <= '0;
      mul_cnt  <= '0;
      mul_sel  <= acc_sel;
    end else if (mul_done) begin
      acc[mul_sel] <= mul_prod_next;
      out          <= mul_prod_next;
      zero         <= (mul_prod_next == '0);
      out_valid    <= 1'b1;
    end else if (state == S_MUL) begin
      mul_prod <= mul_prod_next;
      mul_a    <= mul_a << 1;
      mul_b    <= mul_b >> 1;
      mul_cnt  <= mul_cnt + 1'b1;
    end else if (accept) begin
      if (alu_wr) begin
        acc[acc_sel] <= alu_res;
        zero         <= (alu_res == '0);
      end
      if (alu_carry_wr) begin
        carry <= alu_carry;
      end
      out       <= alu_res;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accum_bank.sv
// tb/tb_accum_bank.sv - scoreboard bench for accum_bank
module tb_accum_bank;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [1:0]  acc_sel;
  logic [31:0] operand;
  logic [31:0] out;
  logic        out_valid;
  logic        carry;
  logic        zero;

  accum_bank #(.WIDTH(32), .NUM_ACC(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .acc_sel   (acc_sel),
    .operand   (operand),
    .out       (out),
    .out_valid (out_valid),
    .carry     (carry),
    .zero      (zero)
  );

  typedef struct {
    logic [31:0] out;
    logic        carry;
    logic        zero;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] m_acc [4];
  logic        m_carry;
  logic        m_zero;
  logic [31:0] last_out;
  int          vectors;
  int          miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_out_valid out=%h", out);
      end else begin
        mon_e = exp_q.pop_front();
        if (out !== mon_e.out || carry !== mon_e.carry || zero !== mon_e.zero) begin
          miscompares++;
          $display("FAIL result out=%h carry=%b zero=%b required out=%h carry=%b zero=%b",
                   out, carry, zero, mon_e.out, mon_e.carry, mon_e.zero);
        end
      end
    end
  end

  task automatic model_push(input logic [3:0] op, input logic [1:0] sel, input logic [31:0] val);
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] a;
    logic [31:0] r;
    bit          wr;
    exp_t        e;
    wr = 1;
    a  = m_acc[sel];
    case (op)
      4'h0: begin s = {1'b0, a} + {1'b0, val}; r = s[31:0]; m_carry = s[32]; end
      4'h1: begin r = a - val; m_carry = (a < val); end
      4'h2: r = val;
      4'h3: r = a & val;
      4'h4: r = a | val;
      4'h5: r = a ^ val;
      4'h6: r = (val >= 32) ? 32'h0 : (a << val);
      4'h7: r = (val >= 32) ? 32'h0 : (a >> val);
      4'h8: begin p = {32'h0, a} * {32'h0, val}; r = p[31:0]; end
      4'h9: r = 32'h0;
      default: begin r = a; wr = 0; end
    endcase
    if (wr) begin
      m_acc[sel] = r;
      m_zero     = (r == 32'h0);
    end
    e.out   = r;
    e.carry = m_carry;
    e.zero  = m_zero;
    exp_q.push_back(e);
    last_out = r;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_acc[i] = 32'h0;
    m_carry  = 1'b0;
    m_zero   = 1'b1;
    last_out = 32'h0;
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [3:0] op, input logic [1:0] sel, input logic [31:0] val);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    opcode   = op;
    acc_sel  = sel;
    operand  = val;
    model_push(op, sel, val);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(3);
    vectors++;
    if (out !== 32'h0 || carry !== 1'b0 || zero !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state out=%h carry=%b zero=%b out_valid=%b in_ready=%b required 0/0/1/0/1",
               out, carry, zero, out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) send(4'hF, 2'(i), 32'h0);
    @(negedge clk);
  endtask

  task automatic test_add_carry();
    send(4'h2, 2'd0, 32'hFFFF_FFFF);
    send(4'h0, 2'd0, 32'h1);
    vectors++;
    if (out_valid !== 1'b1 || out !== 32'h0 || carry !== 1'b1 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL add_wrap out_valid=%b out=%h carry=%b zero=%b required 1/0/1/1", out_valid, out, carry, zero);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_pulse_width out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_sub_borrow();
    send(4'h2, 2'd2, 32'hA5A5_0000);
    send(4'h2, 2'd3, 32'h0000_5A5A);
    send(4'h2, 2'd1, 32'h5);
    send(4'h1, 2'd1, 32'h7);
    vectors++;
    if (out !== 32'hFFFF_FFFE || carry !== 1'b1 || zero !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_borrow out=%h carry=%b zero=%b required fffffffe/1/0", out, carry, zero);
    end
    send(4'hF, 2'd0, 32'h0);
    send(4'hF, 2'd2, 32'h0);
    send(4'hF, 2'd3, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_mul();
    int cnt;
    send(4'h2, 2'd2, 32'h1234);
    send(4'h8, 2'd2, 32'h10);
    cnt = 0;
    while (in_ready === 1'b0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    vectors++;
    if (cnt != 32) begin
      miscompares++;
      $display("FAIL mul_busy_cycles got=%0d required 32", cnt);
    end
    vectors++;
    if (out_valid !== 1'b1 || out !== 32'h0001_2340 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_done out_valid=%b out=%h in_ready=%b required 1/00012340/1", out_valid, out, in_ready);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_pulse_width out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_mul_blocked();
    int cnt;
    send(4'h8, 2'd2, 32'h3);
    cnt = 0;
    while (in_ready === 1'b0 && cnt < 100) begin
      in_valid = 1'b1;
      opcode   = 4'($urandom_range(0, 15));
      acc_sel  = 2'($urandom_range(0, 3));
      operand  = $urandom;
      cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (cnt != 32) begin
      miscompares++;
      $display("FAIL mul_blocked_cycles got=%0d required 32", cnt);
    end
    for (int i = 0; i < 4; i++) send(4'hF, 2'(i), 32'h0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int bad;
    send(4'h8, 2'd1, 32'h7);
    repeat (9) @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b1;
    opcode   = 4'h2;
    acc_sel  = 2'd0;
    operand  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    model_reset();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_abort_mul bad_cycles=%0d required 0", bad);
    end
    vectors++;
    if (out !== 32'h0 || carry !== 1'b0 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_abort_flags out=%h carry=%b zero=%b required 0/0/1", out, carry, zero);
    end
    for (int i = 0; i < 4; i++) send(4'hF, 2'(i), 32'h0);
    @(negedge clk);
  endtask

  task automatic test_shift_nop();
    send(4'h2, 2'd1, 32'h0000_00C3);
    send(4'h2, 2'd3, 32'h8000_0001);
    send(4'h6, 2'd3, 32'h1);
    vectors++;
    if (out !== 32'h0000_0002 || zero !== 1'b0) begin
      miscompares++;
      $display("FAIL shl_one out=%h zero=%b required 00000002/0", out, zero);
    end
    send(4'h7, 2'd3, 32'd40);
    vectors++;
    if (out !== 32'h0 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL shr_big out=%h zero=%b required 0/1", out, zero);
    end
    send(4'hB, 2'd3, 32'h55);
    vectors++;
    if (out_valid !== 1'b1 || out !== 32'h0 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL undef_op out_valid=%b out=%h zero=%b required 1/0/1", out_valid, out, zero);
    end
    send(4'hC, 2'd1, 32'hFFFF);
    send(4'h6, 2'd1, 32'd32);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    logic [3:0] ops [12];
    int         guard;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF, 4'hD};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 11)];
      if (op == 4'h6 || op == 4'h7) send(op, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 40)));
      else send(op, 2'($urandom_range(0, 3)), $urandom);
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_stable();
    int bad;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (out !== last_out || out_valid !== 1'b0 || carry !== m_carry || zero !== m_zero) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL idle_stable bad_cycles=%0d out=%h required %h", bad, out, last_out);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    in_valid    = 1'b0;
    opcode      = 4'h0;
    acc_sel     = 2'd0;
    operand     = 32'h0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_mul();
    test_mul_blocked();
    test_reset_mid_mul();
    test_shift_nop();
    test_back_to_back();
    test_stable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/accum_bank.md
ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of operand, accumulators and result.
REQ-002 SHALL have parameter NUM_ACC, default 4, number of independent accumulators (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-005 SHALL have port in_valid  input  1  command present.
REQ-006 SHALL have port in_ready  output  1  command accepted this cycle if in_valid is also high.
REQ-007 SHALL have port opcode  input  4  operation select.
REQ-008 SHALL have port acc_sel  input  log2(NUM_ACC)  target accumulator index.
REQ-009 SHALL have port operand  input  WIDTH  operand data.
REQ-010 SHALL have port out  output  WIDTH  value of the accumulator written by the last completed command.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse marking a completed command.
REQ-012 SHALL have port carry  output  1  carry/borrow of the last ADD/SUB.
REQ-013 SHALL have port zero  output  1  high when the last written result equals 0.

Function
REQ-014 SHALL decode opcodes: 0x0 ADD acc+op; 0x1 SUB acc-op; 0x2 LOAD op; 0x3 AND; 0x4 OR; 0x5 XOR; 0x6 SHL acc<<op[4:0]; 0x7 SHR (logical) acc>>op[4:0]; 0x8 MUL low WIDTH bits of acc*op; 0x9 CLR to 0; 0xF NO_OP; all other codes treated as NO_OP.
REQ-015 SHALL accept a command on a rising edge where in_valid and in_ready are both high; commands with in_ready low are ignored, not queued.
REQ-016 SHALL implement states IDLE and MUL; in_ready = 1 only in IDLE.
REQ-017 SHALL complete every non-MUL opcode in the accepting edge: target accumulator, out, flags updated on that edge; out_valid high for exactly the following cycle.
REQ-018 SHALL, on accepted MUL, go IDLE->MUL and compute by shift-add, one operand bit per cycle, for exactly WIDTH cycles, then write the target accumulator, out and zero, pulse out_valid for one cycle and return to IDLE; in_ready low throughout MUL; acc_sel and operand captured at acceptance.
REQ-019 SHALL take carry as bit WIDTH of the (WIDTH+1)-bit sum for ADD, and 1 when acc < op (unsigned borrow) for SUB; all arithmetic wraps modulo 2^WIDTH.
REQ-020 SHALL leave carry unchanged on every opcode except ADD/SUB; SHALL update zero on every opcode that writes an accumulator.
REQ-021 SHALL treat SHL/SHR shift counts >= WIDTH as producing 0.
REQ-022 SHALL, for NO_OP/undefined codes, modify no accumulator or flag, set out to the selected accumulator value and still pulse out_valid.
REQ-023 SHALL leave non-selected accumulators unchanged by any command.
REQ-024 SHALL hold out, carry, zero stable between completions.

Reset
REQ-025 SHALL, when reset is low at a rising edge, clear all accumulators, out, carry and set zero=1, out_valid=0, state IDLE; in_ready=1 from the first cycle after reset deasserts.
REQ-026 SHALL abort an in-progress MUL on reset with no accumulator write and no out_valid pulse.
REQ-027 SHALL give reset priority over any simultaneously presented command, which is discarded.

Verification
REQ-028 Bench SHALL cover: reset, LOAD acc0=0xFFFFFFFF, ADD acc0 op=1 -> out=0, carry=1, zero=1, out_valid one cycle.
REQ-029 Bench SHALL cover: LOAD acc1=5, SUB acc1 op=7 -> out=0xFFFFFFFE, carry=1, zero=0; acc0, acc2, acc3 unchanged.
REQ-030 Bench SHALL cover: LOAD acc2=0x1234, MUL acc2 op=0x10 -> in_ready low 32 cycles, then out=0x12340, out_valid one cycle, in_ready back to 1.
REQ-031 Bench SHALL cover: in_valid held high during MUL with other commands -> none executed; only the MUL result appears.
REQ-032 Bench SHALL cover: reset low at cycle 10 of a MUL -> no out_valid, all accumulators 0, in_ready=1 after release.
REQ-033 Bench SHALL cover: acc3=0x80000001, SHL op=1 -> 0x00000002; SHR op=40 -> 0, zero=1; opcode 0xB -> no change, out_valid pulses.
